// File: rtl/fp32_mul_pkg.sv
// Shared constants, FSM state encoding and radix-4 Booth digit recoding
// for the sequential binary32 multiplier.
package fp32_mul_pkg;

   localparam int EXP_W       = 8;
   localparam int MAN_W       = 23;
   localparam int BIAS        = 127;
   localparam int MULT_CYCLES = 12;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      MULT,
      NORM,
      ROUND
   } state_t;

   typedef enum logic [2:0] {
      BD_ZERO,
      BD_POS1,
      BD_POS2,
      BD_NEG1,
      BD_NEG2
   } booth_digit_t;

   // Overlapping bit triple {b[2i+1], b[2i], b[2i-1]} -> digit in {-2..+2}.
   function automatic booth_digit_t booth_encode(input logic [2:0] triple);
      booth_digit_t digit;
      case (triple)
         3'b001, 3'b010: digit = BD_POS1;
         3'b011:         digit = BD_POS2;
         3'b100:         digit = BD_NEG2;
         3'b101, 3'b110: digit = BD_NEG1;
         default:        digit = BD_ZERO;
      endcase
      return digit;
   endfunction

endpackage

// File: rtl/booth_radix4_mult24.sv
// Iterative radix-4 Booth multiplier for 24x24 unsigned operands.
// load consumes digit 0, each step consumes one more digit (12 steps total).
module booth_radix4_mult24
   import fp32_mul_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [23:0] mcand,
   input  logic [23:0] mplier,
   output logic [47:0] product
);

   // The true product is below 2^48, so all accumulation is done modulo 2^48.
   logic [47:0]  acc;
   logic [47:0]  mc_sh;
   logic [26:0]  q_sh;
   logic [26:0]  q_init;
   logic [47:0]  mc_src;
   logic [47:0]  pp;
   logic [2:0]   triple;
   booth_digit_t digit;

   // NOTE: every signal written in always_comb gets a value on every path,
   // otherwise synthesis infers a latch.
   always_comb begin
      q_init = {2'b00, mplier, 1'b0};
      if (load) begin
         triple = q_init[2:0];
         mc_src = 48'(mcand);
      end else begin
         triple = q_sh[2:0];
         mc_src = mc_sh;
      end
      digit = booth_encode(triple);
      case (digit)
         BD_POS1: pp = mc_src;
         BD_POS2: pp = mc_src << 1;
         BD_NEG1: pp = -mc_src;
         BD_NEG2: pp = -(mc_src << 1);
         default: pp = '0;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         mc_sh <= '0;
         q_sh  <= '0;
      end else if (load) begin
         acc   <= pp;
         mc_sh <= 48'(mcand) << 2;
         q_sh  <= q_init >> 2;
      end else if (step) begin
         acc   <= acc + pp;
         mc_sh <= mc_sh << 2;
         q_sh  <= q_sh >> 2;
      end
   end

   assign product = acc;

endmodule

// File: rtl/floating_point_multiplier_single_precision_booth.sv
// Multi-cycle IEEE-754 binary32 multiplier with start/done handshake,
// flush-to-zero on subnormals and round-to-nearest-even; fixed 15-cycle latency.
module floating_point_multiplier_single_precision_booth
   import fp32_mul_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] Mul_Out
);

   state_t             state;
   logic [31:0]        a_reg, b_reg;
   logic               sign_r;
   logic signed [9:0]  exp_r;
   logic               special_r;
   logic [31:0]        special_val_r;
   logic [3:0]         mult_cnt;
   logic [46:0]        norm_sig;
   logic               lost_r;
   logic [47:0]        product;

   logic [EXP_W-1:0]   ea, eb;
   logic [MAN_W-1:0]   fa, fb;
   logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
   logic               sign_ab;

   logic [23:0]        mant24;
   logic               guard, rnd, sticky, round_up;
   logic [24:0]        mant_rnd;
   logic signed [9:0]  exp_fin;
   logic [MAN_W-1:0]   frac_fin;
   logic [31:0]        result;

   booth_radix4_mult24 u_booth (
      .clk     (clk),
      .rst     (rst),
      .load    (state == UNPACK),
      .step    (state == MULT),
      .mcand   ({1'b1, a_reg[MAN_W-1:0]}),
      .mplier  ({1'b1, b_reg[MAN_W-1:0]}),
      .product (product)
   );

   always_comb begin
      ea      = a_reg[MAN_W +: EXP_W];
      eb      = b_reg[MAN_W +: EXP_W];
      fa      = a_reg[MAN_W-1:0];
      fb      = b_reg[MAN_W-1:0];
      sign_ab = a_reg[31] ^ b_reg[31];
      a_zero  = (ea == '0);
      b_zero  = (eb == '0);
      a_inf   = (ea == '1) && (fa == '0);
      b_inf   = (eb == '1) && (fb == '0);
      a_nan   = (ea == '1) && (fa != '0);
      b_nan   = (eb == '1) && (fb != '0);
   end

   // Leading one sits at norm_sig[46]; lost_r keeps the bit shifted out in NORM.
   always_comb begin
      mant24   = norm_sig[46:23];
      guard    = norm_sig[22];
      rnd      = norm_sig[21];
      sticky   = (|norm_sig[20:0]) | lost_r;
      round_up = guard & (rnd | sticky | mant24[0]);
      mant_rnd = {1'b0, mant24} + 25'(round_up);
      exp_fin  = exp_r + 10'(mant_rnd[24]);
      frac_fin = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
      if (special_r)
         result = special_val_r;
      else if (exp_fin >= 10'sd255)
         result = {sign_r, POS_INF[30:0]};
      else if (exp_fin <= 10'sd0)
         result = {sign_r, 31'h0};
      else
         result = {sign_r, exp_fin[7:0], frac_fin};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         Mul_Out       <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         sign_r        <= 1'b0;
         exp_r         <= '0;
         special_r     <= 1'b0;
         special_val_r <= '0;
         mult_cnt      <= '0;
         norm_sig      <= '0;
         lost_r        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= A;
                  b_reg <= B;
                  busy  <= 1'b1;
                  state <= UNPACK;
               end
            end
            UNPACK: begin
               sign_r    <= sign_ab;
               exp_r     <= 10'(ea) + 10'(eb) - 10'(BIAS);
               special_r <= a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
               if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
                  special_val_r <= QNAN;
               else if (a_inf || b_inf)
                  special_val_r <= {sign_ab, POS_INF[30:0]};
               else
                  special_val_r <= {sign_ab, 31'h0};
               mult_cnt <= '0;
               state    <= MULT;
            end
            MULT: begin
               mult_cnt <= mult_cnt + 4'd1;
               if (mult_cnt == 4'(MULT_CYCLES - 1))
                  state <= NORM;
            end
            NORM: begin
               if (product[47]) begin
                  norm_sig <= product[47:1];
                  lost_r   <= product[0];
                  exp_r    <= exp_r + 10'sd1;
               end else begin
                  norm_sig <= product[46:0];
                  lost_r   <= 1'b0;
               end
               state <= ROUND;
            end
            ROUND: begin
               Mul_Out <= result;
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_floating_point_multiplier_single_precision_booth.sv
// Self-checking bench: directed vector table, handshake/reset sequences and
// randomized operands compared against a real-arithmetic reference model.
module tb_floating_point_multiplier_single_precision_booth;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] A, B;
   logic        busy, done;
   logic [31:0] Mul_Out;

   int n_tests = 0;
   int n_fail  = 0;

   floating_point_multiplier_single_precision_booth dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .done    (done),
      .Mul_Out (Mul_Out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: exact product in double precision, then RNE to 24 bits,
   // then flush/saturate on the final binary32 exponent.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      int          ea, eb, e;
      logic [22:0] fa, fb;
      real         ra, rb, p;
      logic [63:0] pb;
      logic [24:0] keep;
      logic [28:0] rem;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      fa = a[22:0];
      fb = b[22:0];
      if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) ||
          (ea == 255 && eb == 0) || (eb == 255 && ea == 0))
         return 32'h7FC0_0000;
      if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
      if (ea == 0 || eb == 0) return {s, 31'h0};
      ra = $bitstoreal({1'b0, 11'(ea + 896), fa, 29'h0});
      rb = $bitstoreal({1'b0, 11'(eb + 896), fb, 29'h0});
      p  = ra * rb;
      pb = $realtobits(p);
      e    = int'(pb[62:52]) - 1023 + 127;
      keep = {2'b01, pb[51:29]};
      rem  = pb[28:0];
      if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) keep = keep + 25'd1;
      if (keep[24]) begin
         e++;
         keep = keep >> 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0) return {s, 31'h0};
      return {s, 8'(e), keep[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      int          sel;
      logic [31:0] r;
      sel = $urandom_range(0, 15);
      r   = $urandom;
      case (sel)
         0:       return r;
         1:       return {r[31], 8'h00, r[22:0]};
         2:       return {r[31], 8'hFF, (r[0] ? r[22:0] : 23'h0)};
         3:       return {r[31], 8'($urandom_range(1, 254)), r[22:0]};
         4:       return {r[31], 8'($urandom_range(100, 154)), 23'h7F_FFFF};
         default: return {r[31], 8'($urandom_range(64, 190)), r[22:0]};
      endcase
   endfunction

   // lat = edges after the sampling edge until done is seen; -1 on timeout.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
      @(negedge clk);
      A = a;
      B = b;
      start = 1'b1;
      lat = -1;
      res = 32'hDEAD_BEEF;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (done) begin
            res = Mul_Out;
            return;
         end
      end
      lat = -1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] res;
      int          lat;
      int          d_cnt;
      int          d_k[2];
      logic [31:0] d_v[2];
      logic [31:0] ra, rb;

      rst = 1'b1;
      start = 1'b0;
      A = '0;
      B = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_out", Mul_Out, 32'h0);
      rst = 1'b0;

      vecs.push_back('{32'hC190_0000, 32'hC118_0000, 32'h432B_0000});
      vecs.push_back('{32'hC1A0_0000, 32'h4220_0000, 32'hC448_0000});
      vecs.push_back('{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000});
      vecs.push_back('{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000});
      vecs.push_back('{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000});
      vecs.push_back('{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000});
      vecs.push_back('{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000});
      vecs.push_back('{32'h0080_0000, 32'h0080_0000, 32'h0000_0000});
      vecs.push_back('{32'h0000_0001, 32'h4000_0000, 32'h0000_0000});
      vecs.push_back('{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002});
      vecs.push_back('{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE});
      vecs.push_back('{32'h8000_0000, 32'hFF80_0000, 32'h7FC0_0000});
      vecs.push_back('{32'h3F80_0000, 32'hFFC0_0000, 32'h7FC0_0000});
      vecs.push_back('{32'hC000_0000, 32'h7F80_0000, 32'hFF80_0000});
      vecs.push_back('{32'h0000_0000, 32'h8000_0000, 32'h8000_0000});
      vecs.push_back('{32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002});
      vecs.push_back('{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000});

      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, res, lat);
         check($sformatf("vec%0d_%h_x_%h", i, vecs[i].a, vecs[i].b), res, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd15);
      end

      // busy high after edges 0..14, single done pulse after edge 15
      @(negedge clk);
      A = 32'hC1A0_0000;
      B = 32'h4220_0000;
      start = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         @(negedge clk);
         start = 1'b0;
         check($sformatf("busy_k%0d", k), 32'(busy), 32'(k <= 14));
         check($sformatf("done_k%0d", k), 32'(done), 32'(k == 15));
         if (k == 15) check("busy_seq_out", Mul_Out, 32'hC448_0000);
      end

      // start pulsed while busy must be ignored; operands are latched at accept
      @(negedge clk);
      A = 32'h4040_0000;
      B = 32'h40A0_0000;
      start = 1'b1;
      d_cnt = 0;
      for (int k = 0; k < 36; k++) begin
         @(negedge clk);
         start = (k == 4);
         if (k == 4) begin
            A = 32'h42C8_0000;
            B = 32'h42C8_0000;
         end
         if (done) d_cnt++;
         if (k == 15) check("ignore_start_out", Mul_Out, 32'h4170_0000);
      end
      check("ignore_start_done_count", 32'(d_cnt), 32'd1);
      check("ignore_start_hold", Mul_Out, 32'h4170_0000);

      // reset sampled at edge 7 of an operation aborts it
      @(negedge clk);
      A = 32'h3FC0_0000;
      B = 32'h4000_0000;
      start = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_out", Mul_Out, 32'h0);
      rst = 1'b0;
      d_cnt = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (done) d_cnt++;
      end
      check("abort_no_done", 32'(d_cnt), 32'd0);
      do_op(32'h3FC0_0000, 32'h4000_0000, res, lat);
      check("after_abort_out", res, 32'h4040_0000);

      // start held high: next op accepted at the edge closing the done cycle
      @(negedge clk);
      A = 32'hC190_0000;
      B = 32'hC118_0000;
      start = 1'b1;
      d_cnt = 0;
      d_k[0] = -1;
      d_k[1] = -1;
      d_v[0] = '0;
      d_v[1] = '0;
      for (int k = 0; k < 60 && d_cnt < 2; k++) begin
         @(negedge clk);
         if (done) begin
            d_k[d_cnt] = k;
            d_v[d_cnt] = Mul_Out;
            d_cnt++;
            if (d_cnt == 1) begin
               A = 32'h3FFF_FFFF;
               B = 32'h3FFF_FFFF;
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      check("b2b_count", 32'(d_cnt), 32'd2);
      check("b2b_first_edge", 32'(d_k[0]), 32'd15);
      check("b2b_second_edge", 32'(d_k[1]), 32'd31);
      check("b2b_first_out", d_v[0], 32'h432B_0000);
      check("b2b_second_out", d_v[1], 32'h407F_FFFE);

      for (int n = 0; n < 300; n++) begin
         ra = rand_fp();
         rb = rand_fp();
         do_op(ra, rb, res, lat);
         check($sformatf("rand%0d_%h_x_%h", n, ra, rb), res, ref_mul(ra, rb));
         if (lat != 15) check($sformatf("rand%0d_latency", n), 32'(lat), 32'd15);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
